cu_cache_request_arbiter: RTL and testbench

CU_CACHE_REQUEST_ARBITER -- requirements
Module: cu_cache_request_arbiter

---
 rtl/cu_cache_request_arbiter_if.sv | 46 ++++
 rtl/cu_cache_request_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_cu_cache_request_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_cache_request_arbiter_if.sv
// Shared request types and the source/cache request bus of the CU cache request arbiter.
// Ports (bus): request_in, request_ready_out, request_out, grant_id_out; slave = arbiter, master = sources/cache.
package cu_cache_request_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic [31:0] data;
    } CacheRequest;

    typedef struct packed {
        logic full;
        logic empty;
        logic prog_full;
        logic prog_empty;
    } FIFOStateSignalsOutput;

endpackage

interface cu_cache_request_arbiter_if #(
    parameter int NUM_REQUESTORS = 4
);
    import cu_cache_request_arbiter_pkg::*;

    localparam int ID_W = $clog2(NUM_REQUESTORS);

    CacheRequest [NUM_REQUESTORS-1:0] request_in;
    logic [NUM_REQUESTORS-1:0]        request_ready_out;
    CacheRequest                      request_out;
    logic [ID_W-1:0]                  grant_id_out;

    modport slave (
        input  request_in,
        output request_ready_out,
        output request_out,
        output grant_id_out
    );

    modport master (
        output request_in,
        input  request_ready_out,
        input  request_out,
        input  grant_id_out
    );

endinterface

// File: rtl/cu_cache_request_arbiter.sv
// Round-robin arbiter: per-source skid buffers feed one registered request stream to the cache FIFO.
// Ports: ap_clk, areset (async, high), req_if (slave bus), fifo_request_signals_in (prog_full), done_out, stats_out.
// Optional macro ARBITER_GRANT_STATS_EN builds saturating per-source grant counters on stats_out.
module cu_cache_request_arbiter
    import cu_cache_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTORS = 4,
    parameter int SKID_DEPTH     = 2
) (
    input  logic                           ap_clk,
    input  logic                           areset,
    cu_cache_request_arbiter_if.slave      req_if,
    input  FIFOStateSignalsOutput          fifo_request_signals_in,
    output logic                           done_out,
    output logic [NUM_REQUESTORS-1:0][31:0] stats_out
);

    localparam int ID_W  = $clog2(NUM_REQUESTORS);
    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_STALL
    } state_t;

    state_t state;
    state_t state_nxt;

    CacheRequest skid_mem [NUM_REQUESTORS][SKID_DEPTH];

    logic [NUM_REQUESTORS-1:0][PTR_W-1:0] wr_ptr;
    logic [NUM_REQUESTORS-1:0][PTR_W-1:0] rd_ptr;
    logic [NUM_REQUESTORS-1:0][OCC_W-1:0] occ;
    logic [NUM_REQUESTORS-1:0][OCC_W-1:0] occ_nxt;

    logic [NUM_REQUESTORS-1:0] push;
    logic [NUM_REQUESTORS-1:0] pop;
    logic [NUM_REQUESTORS-1:0] nonempty;
    logic [NUM_REQUESTORS-1:0] ready_q;
    logic [NUM_REQUESTORS-1:0] ready_nxt;

    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] winner;
    logic            winner_found;
    logic            pop_en;
    logic            any_pending;
    logic            any_after;
    logic            prog_full;

    CacheRequest     head;
    CacheRequest     request_q;
    logic [ID_W-1:0] grant_q;

    logic unused_fifo_bits;

    assign prog_full = fifo_request_signals_in.prog_full;

    assign unused_fifo_bits = ^{fifo_request_signals_in.full,
                                fifo_request_signals_in.empty,
                                fifo_request_signals_in.prog_empty};

    assign req_if.request_ready_out = ready_q;
    assign req_if.request_out       = request_q;
    assign req_if.grant_id_out      = grant_q;

    function automatic logic [ID_W-1:0] rr_index(
        input logic [ID_W-1:0] base,
        input int              off
    );
        return ID_W'((int'(base) + off) % NUM_REQUESTORS);
    endfunction

    // Search begins one past the last winner so every source gets a turn.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        for (int k = 1; k <= NUM_REQUESTORS; k++) begin
            if (!winner_found && nonempty[rr_index(last_grant, k)]) begin
                winner       = rr_index(last_grant, k);
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        push      = '0;
        pop       = '0;
        nonempty  = '0;
        occ_nxt   = occ;
        ready_nxt = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            nonempty[i] = (occ[i] != '0);
            push[i]     = req_if.request_in[i].valid & ready_q[i];
            pop[i]      = pop_en && (winner == ID_W'(i));
            occ_nxt[i]  = occ[i] + OCC_W'(push[i]) - OCC_W'(pop[i]);
            // One free slot left is only safe to advertise if it is being drained now.
            ready_nxt[i] = (occ[i] <= OCC_W'(SKID_DEPTH - 2)) ||
                           ((occ[i] == OCC_W'(SKID_DEPTH - 1)) && pop[i]);
        end
    end

    assign any_pending = |nonempty;

    always_comb begin
        any_after = 1'b0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            any_after = any_after | (occ_nxt[i] != '0);
        end
    end

    assign head = skid_mem[winner][rd_ptr[winner]];

    always_comb begin
        state_nxt = state;
        pop_en    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (any_pending) begin
                    state_nxt = prog_full ? S_STALL : S_ISSUE;
                end
            end
            S_ISSUE: begin
                pop_en = winner_found;
                if (prog_full) begin
                    state_nxt = S_STALL;
                end else if (!any_after) begin
                    state_nxt = S_IDLE;
                end
            end
            S_STALL: begin
                if (!prog_full) begin
                    state_nxt = any_pending ? S_ISSUE : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            ready_q    <= '0;
            last_grant <= ID_W'(NUM_REQUESTORS - 1);
            request_q  <= '0;
            grant_q    <= '0;
            done_out   <= 1'b1;
        end else begin
            state   <= state_nxt;
            occ     <= occ_nxt;
            ready_q <= ready_nxt;
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
            if (pop_en) begin
                last_grant <= winner;
                request_q  <= head;
                grant_q    <= winner;
            end else begin
                request_q.valid <= 1'b0;
            end
            done_out <= ~any_pending & ~request_q.valid;
        end
    end

    // Storage needs no reset: pointers and occupancy define what is live.
    always_ff @(posedge ap_clk) begin
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            if (push[i]) begin
                skid_mem[i][wr_ptr[i]] <= req_if.request_in[i];
            end
        end
    end

`ifdef ARBITER_GRANT_STATS_EN
    logic [NUM_REQUESTORS-1:0][31:0] grant_cnt;

    always_ff @(posedge ap_clk or posedge areset) begin
        if (areset) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                if (pop[i] && (grant_cnt[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign stats_out = grant_cnt;
`else
    assign stats_out = '0;
`endif

endmodule

// File: tb/tb_cu_cache_request_arbiter.sv
// Directed bench for cu_cache_request_arbiter.
// Source queues feed the bus; a per-source scoreboard checks payload and order.
module tb_cu_cache_request_arbiter;
    import cu_cache_request_arbiter_pkg::*;

    localparam int N = 4;

    logic ap_clk = 1'b0;
    logic areset;
    FIFOStateSignalsOutput fifo_st;
    logic done_out;
    logic [N-1:0][31:0] stats_out;

    always #5 ap_clk = ~ap_clk;

    cu_cache_request_arbiter_if #(.NUM_REQUESTORS(N)) bus ();

    cu_cache_request_arbiter #(
        .NUM_REQUESTORS(N),
        .SKID_DEPTH(2)
    ) dut (
        .ap_clk(ap_clk),
        .areset(areset),
        .req_if(bus),
        .fifo_request_signals_in(fifo_st),
        .done_out(done_out),
        .stats_out(stats_out)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] pend [N][$];
    logic [63:0] sb [N][$];
    int grants [N];

    logic [63:0] e;
    logic [N-1:0][31:0] exp_s;
    int prev;
    int g1;
    int g3;
    int seq1;
    int seq3;
    int vcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int src, input int n);
        return {8'(src), 24'(n), 32'hC0DE_0000 | 32'(n)};
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0 || sb[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pend[i].size() != 0) bus.request_in[i] = {1'b1, pend[i][0]};
            else bus.request_in[i] = '0;
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        logic [63:0] want;
        int gid;
        drive();
        for (int i = 0; i < N; i++) begin
            acc[i] = bus.request_in[i].valid & bus.request_ready_out[i];
        end
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) sb[i].push_back(pend[i].pop_front());
        end
        if (bus.request_out.valid) begin
            gid = int'(bus.grant_id_out);
            grants[gid]++;
            if (sb[gid].size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                want = sb[gid].pop_front();
                chk("sb_payload", {bus.request_out.address, bus.request_out.data}, want);
            end
        end
        drive();
    endtask

    task automatic drain(input string tag);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 300) begin
            tick();
            n++;
            busy = !(done_out && all_empty());
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        for (int i = 0; i < N; i++) begin
            pend[i].delete();
            sb[i].delete();
            grants[i] = 0;
        end
        drive();
        #1;
        chk("rst_valid", 64'(bus.request_out.valid), 64'd0);
        chk("rst_grant", 64'(bus.grant_id_out), 64'd0);
        chk("rst_ready", 64'(bus.request_ready_out), 64'd0);
        chk("rst_done", 64'(done_out), 64'd1);
        for (int i = 0; i < N; i++) chk("rst_stats", 64'(stats_out[i]), 64'd0);
        @(posedge ap_clk);
        #1;
        areset = 1'b0;
        tick();
        chk("ready_rise", 64'(bus.request_ready_out), 64'hF);
    endtask

    initial begin
        areset = 1'b1;
        fifo_st = '0;
        bus.request_in = '0;
        apply_reset();

        // Single source, three requests. Depth 2 drops ready after two
        // accepts, so the third is accepted at E4 and issues at E6.
        for (int n = 0; n < 3; n++) pend[0].push_back(mk(0, n));
        tick();
        chk("t1_e0_valid", 64'(bus.request_out.valid), 64'd0);
        tick();
        chk("t1_e1_valid", 64'(bus.request_out.valid), 64'd0);
        tick();
        e = mk(0, 0);
        chk("t1_e2_valid", 64'(bus.request_out.valid), 64'd1);
        chk("t1_e2_gid", 64'(bus.grant_id_out), 64'd0);
        chk("t1_e2_pay", {bus.request_out.address, bus.request_out.data}, e);
        tick();
        e = mk(0, 1);
        chk("t1_e3_valid", 64'(bus.request_out.valid), 64'd1);
        chk("t1_e3_pay", {bus.request_out.address, bus.request_out.data}, e);
        tick();
        chk("t1_e4_valid", 64'(bus.request_out.valid), 64'd0);
        tick();
        chk("t1_e5_valid", 64'(bus.request_out.valid), 64'd0);
        tick();
        e = mk(0, 2);
        chk("t1_e6_valid", 64'(bus.request_out.valid), 64'd1);
        chk("t1_e6_gid", 64'(bus.grant_id_out), 64'd0);
        chk("t1_e6_pay", {bus.request_out.address, bus.request_out.data}, e);
        tick();
        chk("t1_e7_done", 64'(done_out), 64'd0);
        tick();
        chk("t1_e8_done", 64'(done_out), 64'd1);

        // All four sources, one request each, right after reset.
        apply_reset();
        for (int i = 0; i < N; i++) pend[i].push_back(mk(i, 100));
        tick();
        chk("t2_e0_valid", 64'(bus.request_out.valid), 64'd0);
        tick();
        chk("t2_e1_valid", 64'(bus.request_out.valid), 64'd0);
        for (int k = 0; k < N; k++) begin
            tick();
            chk("t2_issue_valid", 64'(bus.request_out.valid), 64'd1);
            chk("t2_issue_gid", 64'(bus.grant_id_out), 64'(k));
        end
        tick();
        chk("t2_e6_valid", 64'(bus.request_out.valid), 64'd0);
        chk("t2_e6_done", 64'(done_out), 64'd0);
        tick();
        chk("t2_e7_done", 64'(done_out), 64'd1);

        // prog_full holds two entries of source 2 back.
        fifo_st.prog_full = 1'b1;
        pend[2].push_back(mk(2, 200));
        pend[2].push_back(mk(2, 201));
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_stall_valid", 64'(bus.request_out.valid), 64'd0);
            chk("t3_stall_ready", 64'(bus.request_ready_out[2]), 64'd0);
        end
        fifo_st.prog_full = 1'b0;
        tick();
        chk("t3_e7_valid", 64'(bus.request_out.valid), 64'd0);
        tick();
        chk("t3_e8_valid", 64'(bus.request_out.valid), 64'd1);
        chk("t3_e8_gid", 64'(bus.grant_id_out), 64'd2);
        chk("t3_e8_ready", 64'(bus.request_ready_out[2]), 64'd0);
        tick();
        chk("t3_e9_valid", 64'(bus.request_out.valid), 64'd1);
        chk("t3_e9_gid", 64'(bus.grant_id_out), 64'd2);
        chk("t3_e9_ready", 64'(bus.request_ready_out[2]), 64'd1);

        // Sources 1 and 3 always valid: grants must alternate.
        prev = -1;
        g1 = 0;
        g3 = 0;
        seq1 = 0;
        seq3 = 0;
        for (int c = 0; c < 100; c++) begin
            if (pend[1].size() == 0) pend[1].push_back(mk(1, seq1++));
            if (pend[3].size() == 0) pend[3].push_back(mk(3, seq3++));
            tick();
            if (bus.request_out.valid) begin
                if (prev >= 0) begin
                    chk("t4_rr_alt", 64'(int'(bus.grant_id_out) != prev), 64'd1);
                end
                prev = int'(bus.grant_id_out);
                if (prev == 1) g1++;
                if (prev == 3) g3++;
            end
        end
        chk("t4_g1_min", 64'(g1 >= 40), 64'd1);
        chk("t4_g3_min", 64'(g3 >= 40), 64'd1);
        pend[1].delete();
        pend[3].delete();
        drain("t4_drain");

        // Reset while three entries are still buffered.
        pend[0].push_back(mk(0, 300));
        pend[0].push_back(mk(0, 301));
        pend[1].push_back(mk(1, 300));
        pend[2].push_back(mk(2, 300));
        tick();
        tick();
        tick();
        chk("t5_busy_valid", 64'(bus.request_out.valid), 64'd1);
        apply_reset();
        vcnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.request_out.valid) vcnt++;
        end
        chk("t5_no_issue", 64'(vcnt), 64'd0);
        chk("t5_done", 64'(done_out), 64'd1);
        pend[1].push_back(mk(1, 400));
        tick();
        tick();
        tick();
        chk("t5_new_valid", 64'(bus.request_out.valid), 64'd1);
        chk("t5_new_gid", 64'(bus.grant_id_out), 64'd1);

        // Grant statistics: 10 pops from source 0, 4 from source 2.
        apply_reset();
        for (int n = 0; n < 10; n++) pend[0].push_back(mk(0, 500 + n));
        for (int n = 0; n < 4; n++) pend[2].push_back(mk(2, 500 + n));
        drain("t6_drain");
        chk("t6_grants0", 64'(grants[0]), 64'd10);
        chk("t6_grants2", 64'(grants[2]), 64'd4);
`ifdef ARBITER_GRANT_STATS_EN
        exp_s = {32'd0, 32'd4, 32'd0, 32'd10};
`else
        exp_s = '0;
`endif
        for (int i = 0; i < N; i++) begin
            chk("t6_stats", 64'(stats_out[i]), 64'(exp_s[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
